uart_cmd_link: RTL

UART_CMD_LINK -- requirements
Module: uart_cmd_link

---
 rtl/uart_cmd_pkg.sv | 27 ++
 rtl/uart_cmd_link_if.sv | 15 +
 rtl/uart_rsp_framer.sv | 61 ++++++
 rtl/uart_cmd_link.sv | 92 +++++++++
 4 files changed

// File: rtl/uart_cmd_pkg.sv
// Shared constants, FSM state types and frame helpers for the UART command link.
package uart_cmd_pkg;

  localparam logic [7:0] RX_SYNC   = 8'hA5;
  localparam logic [7:0] TX_SYNC   = 8'h5A;
  localparam int         FRAME_LEN = 5;

  typedef enum logic [2:0] {R_IDLE, R_OPC, R_ARGH, R_ARGL, R_CHK} rx_state_t;
  typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;

  typedef struct packed {
    logic [7:0]  status;
    logic [15:0] data;
  } rsp_t;

  // Byte idx of the outgoing response frame; the last slot is the XOR check.
  function automatic logic [7:0] rsp_byte(input rsp_t r, input logic [2:0] idx);
    case (idx)
      3'd0:    rsp_byte = TX_SYNC;
      3'd1:    rsp_byte = r.status;
      3'd2:    rsp_byte = r.data[15:8];
      3'd3:    rsp_byte = r.data[7:0];
      default: rsp_byte = r.status ^ r.data[15:8] ^ r.data[7:0];
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_link_if.sv
// Response/transmit handshake bundle between the link and its response framer.
interface uart_cmd_link_if;
  logic        tx_busy;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        rsp_valid;
  logic [7:0]  rsp_status;
  logic [15:0] rsp_data;
  logic        rsp_ready;

  modport master (input  tx_busy, rsp_valid, rsp_status, rsp_data,
                  output tx_data, tx_start, rsp_ready);
  modport slave  (output tx_busy, rsp_valid, rsp_status, rsp_data,
                  input  tx_data, tx_start, rsp_ready);
endinterface

// File: rtl/uart_rsp_framer.sv
// Serialises one captured response into a 5-byte frame, pacing bytes on tx_busy.
module uart_rsp_framer
  import uart_cmd_pkg::*;
(
  input logic             input_clk,
  input logic             reset_n,
  uart_cmd_link_if.master bus
);

  tx_state_t  state;
  rsp_t       rsp_q;
  logic [2:0] idx;
  logic [1:0] wait_cnt;

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= T_IDLE;
      rsp_q         <= '0;
      idx           <= '0;
      wait_cnt      <= '0;
      bus.tx_start  <= 1'b0;
      bus.tx_data   <= '0;
      bus.rsp_ready <= 1'b0;
    end else begin
      bus.tx_start <= 1'b0;
      case (state)
        T_IDLE: begin
          bus.rsp_ready <= 1'b1;
          if (bus.rsp_valid && bus.rsp_ready) begin
            rsp_q         <= '{status: bus.rsp_status, data: bus.rsp_data};
            idx           <= '0;
            bus.rsp_ready <= 1'b0;
            state         <= T_SEND;
          end
        end
        T_SEND: if (!bus.tx_busy) begin
          bus.tx_start <= 1'b1;
          bus.tx_data  <= rsp_byte(rsp_q, idx);
          wait_cnt     <= '0;
          state        <= T_WAIT;
        end
        // The transmitter raises busy a cycle or two late; skip those edges.
        T_WAIT: begin
          if (wait_cnt != 2'd2)
            wait_cnt <= wait_cnt + 2'd1;
          else if (!bus.tx_busy) begin
            if (idx == 3'(FRAME_LEN - 1)) begin
              state         <= T_IDLE;
              bus.rsp_ready <= 1'b1;
            end else begin
              idx   <= idx + 3'd1;
              state <= T_SEND;
            end
          end
        end
        default: state <= T_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_cmd_link.sv
// UART command link: decodes 5-byte command frames and frames responses back out.
module uart_cmd_link
  import uart_cmd_pkg::*;
#(
  parameter int INPUT_CLK_KHZ = 100_000,
  parameter int TIMEOUT_US    = 1000
) (
  input  logic        input_clk,
  input  logic        reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  output logic        cmd_valid,
  output logic [7:0]  cmd_opcode,
  output logic [15:0] cmd_arg,
  output logic        frame_err,
  input  logic        rsp_valid,
  input  logic [7:0]  rsp_status,
  input  logic [15:0] rsp_data,
  output logic        rsp_ready
);

  localparam int TIMEOUT_CYCLES = INPUT_CLK_KHZ * TIMEOUT_US / 1000;
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);

  rx_state_t  state;
  logic [CNT_W-1:0] gap_cnt;
  logic [7:0] opc_q, argh_q, argl_q;

  always_ff @(posedge input_clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= R_IDLE;
      gap_cnt    <= '0;
      opc_q      <= '0;
      argh_q     <= '0;
      argl_q     <= '0;
      cmd_valid  <= 1'b0;
      frame_err  <= 1'b0;
      cmd_opcode <= '0;
      cmd_arg    <= '0;
    end else begin
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      // A byte arriving on the expiry cycle wins over the timeout.
      if (rx_valid) begin
        gap_cnt <= '0;
        case (state)
          R_IDLE: if (rx_data == RX_SYNC) state <= R_OPC;
          R_OPC:  begin opc_q  <= rx_data; state <= R_ARGH; end
          R_ARGH: begin argh_q <= rx_data; state <= R_ARGL; end
          R_ARGL: begin argl_q <= rx_data; state <= R_CHK;  end
          R_CHK: begin
            if (rx_data == (opc_q ^ argh_q ^ argl_q)) begin
              cmd_valid  <= 1'b1;
              cmd_opcode <= opc_q;
              cmd_arg    <= {argh_q, argl_q};
            end else
              frame_err <= 1'b1;
            state <= R_IDLE;
          end
          default: state <= R_IDLE;
        endcase
      end else if (state != R_IDLE) begin
        if (gap_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          frame_err <= 1'b1;
          gap_cnt   <= '0;
          state     <= R_IDLE;
        end else
          gap_cnt <= gap_cnt + 1'b1;
      end
    end
  end

  uart_cmd_link_if link ();

  assign link.tx_busy    = tx_busy;
  assign link.rsp_valid  = rsp_valid;
  assign link.rsp_status = rsp_status;
  assign link.rsp_data   = rsp_data;
  assign tx_data         = link.tx_data;
  assign tx_start        = link.tx_start;
  assign rsp_ready       = link.rsp_ready;

  uart_rsp_framer u_framer (
    .input_clk (input_clk),
    .reset_n   (reset_n),
    .bus       (link.master)
  );

endmodule
